gpio_serial_loader: RTL and testbench
=====================================

// Module: gpio_serial_loader
// PURPOSE
//  Transmit side of the GPIO pad-configuration serial chain. Holds one config word per pad in a
//  local register array written by the SoC. On a start pulse, it drives serial_shift_rstn,
//  serial_clock, serial_data and serial_load into the first gpio_control_block of gpio_pads_top.
//  It shifts all words down the chain and then strobes load, so every pad latches its new setting.
// PARAMETERS
//  OPENFRAME_IO_PADS  9        number of pads (control blocks) in the chain
//  PAD_CTRL_BITS      16       config bits per pad
//  GPIO_DEFAULTS      16'h3000 reset value of every config word
//  CLK_DIV            1        mclk cycles per serial_clock phase; must be >= 1
// PORTS
//  mclk               in   1    single clock; all logic on rising edge
//  reset              in   1    synchronous, active-high reset
//  cfg_wr             in   1    write strobe for the config array
//  cfg_addr           in   clog2(OPENFRAME_IO_PADS)  pad index for write/read
//  cfg_wdata          in   PAD_CTRL_BITS  write data
//  cfg_rdata          out  PAD_CTRL_BITS  combinational readback of word[cfg_addr]; 0 if out of range
//  start              in   1    one-cycle request to shift the whole array out
//  busy               out  1    high from the cycle after start is accepted until done
//  done               out  1    one-cycle pulse when the load strobe completes
//  serial_shift_rstn  out  1    active-low clear of the chain shift registers
//  serial_clock       out  1    chain shift clock
//  serial_data        out  1    chain data, stable while serial_clock is low and rises
//  serial_load        out  1    chain load strobe
// BEHAVIOUR
//  Reset: all words = GPIO_DEFAULTS; state IDLE; busy=0, done=0, serial_clock=0, serial_data=0,
//   serial_load=0, serial_shift_rstn=1. Reset mid-operation aborts at once to this state, with no load strobe.
//  Let D=CLK_DIV, B=OPENFRAME_IO_PADS*PAD_CTRL_BITS. Bit counter width clog2(B+1). Phase counter width clog2(D+1).
//  Config writes: a word is written on the mclk edge with cfg_wr=1 and addr<N in IDLE only.
//   Writes while busy, or with addr>=N, are dropped silently.
//  FSM:
//   IDLE  - start=1 -> SRST. Start while busy is ignored, not queued.
//   SRST  - serial_shift_rstn=0 for D cycles -> SHIFT_LO.
//   SHIFT_LO - serial_clock=0 and serial_data=current bit for D cycles -> SHIFT_HI.
//   SHIFT_HI - serial_clock=1 with serial_data held for D cycles.
//    Then -> SHIFT_LO with the next bit, or -> LOAD after bit B-1.
//   LOAD  - serial_clock=0, serial_data=0, serial_load=1 for D cycles -> DONE.
//   DONE  - done=1 for one cycle, busy drops in the same cycle -> IDLE.
//  Bit order: the word for pad N-1 goes first and the word for pad 0 goes last, each MSB first.
//   After B rising edges, pad k therefore holds word[k].
//  The data for each bit is captured from the array when its SHIFT_LO phase is entered.
//   The array cannot change while busy.
//  Latency: with start sampled at edge k, done is high in cycle k+2D+2DB+1.
//   For D=1 and N=9 that is cycle k+291.
//  busy is high from cycle k+1 through the DONE cycle.
//  start and cfg_wr in the same IDLE cycle: the write lands and the shift sends the new value.
//  start during DONE is ignored.
//  All serial outputs are registered, so there are no glitches.
//  serial_clock makes exactly B rising edges per operation.
// TESTING
//  1. Reset then start, D=1, N=9. Expect serial_shift_rstn low for 1 cycle, then 144 clock rises,
//     each pad receiving 16'h3000. Expect one load pulse, and done at start+291.
//  2. Write word[0]=16'hA5C3 and word[8]=16'h0001, then start. Model gpio_control_block shift regs.
//     After load, pad0=A5C3, pad8=0001, all other pads 3000. Check the first bit sent is word[8] MSB (0).
//  3. D=3. Expect each clock phase 3 cycles, SRST and LOAD 3 cycles each, done at start+871.
//     Expect data never to change while serial_clock=1.
//  4. Pulse start again at cycle start+50, and cfg_wr addr=2 data=FFFF during busy.
//     Expect no restart, word[2] unchanged, cfg_rdata(2)=3000.
//  5. Assert reset at bit 70 of shifting. Next cycle expect all outputs at reset values,
//     no serial_load pulse, and word[*] back to 3000.
//  6. Write with cfg_addr=9 and data 1234. Expect no array change and cfg_rdata=0 for addr 9.

Source files
------------

// File: rtl/gpio_serial_loader.sv
// Transmit side of the GPIO pad-configuration serial chain.
// Holds one config word per pad. On start it clears the chain and shifts every word out,
// pad N-1 first and MSB first. It then strobes load so that each pad latches its word.
module gpio_serial_loader #(
  parameter int unsigned               OPENFRAME_IO_PADS = 9,
  parameter int unsigned               PAD_CTRL_BITS     = 16,
  parameter logic [PAD_CTRL_BITS-1:0]  GPIO_DEFAULTS     = 16'h3000,
  parameter int unsigned               CLK_DIV           = 1
) (
  input  logic                                  mclk,
  input  logic                                  reset,
  input  logic                                  cfg_wr,
  input  logic [$clog2(OPENFRAME_IO_PADS)-1:0]  cfg_addr,
  input  logic [PAD_CTRL_BITS-1:0]              cfg_wdata,
  output logic [PAD_CTRL_BITS-1:0]              cfg_rdata,
  input  logic                                  start,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  serial_shift_rstn,
  output logic                                  serial_clock,
  output logic                                  serial_data,
  output logic                                  serial_load
);

  localparam int unsigned N  = OPENFRAME_IO_PADS;
  localparam int unsigned P  = PAD_CTRL_BITS;
  localparam int unsigned B  = N * P;
  localparam int unsigned D  = CLK_DIV;
  localparam int unsigned AW = $clog2(N);
  localparam int unsigned BW = $clog2(B + 1);
  localparam int unsigned PW = $clog2(D + 1);

  localparam logic [BW-1:0] LastBit  = BW'(B - 1);
  localparam logic [PW-1:0] LastPh   = PW'(D - 1);
  localparam logic [AW:0]   NumPads  = (AW + 1)'(N);

  typedef enum logic [2:0] {StIdle, StSrst, StShiftLo, StShiftHi, StLoad, StDone} state_e;

  state_e         state_q;
  logic [PW-1:0]  ph_q;
  logic [BW-1:0]  bit_q;
  logic [P-1:0]   words [N];
  logic [B-1:0]   flat;
  logic           addr_ok;

  assign addr_ok = ({1'b0, cfg_addr} < NumPads);

  // Flatten the array so that send-order bit i is flat[B-1-i]: pad N-1 MSB leaves first.
  always_comb begin
    flat = '0;
    for (int k = 0; k < N; k++) flat[k*P +: P] = words[k];
  end

  // Combinational readback; out-of-range addresses read as zero.
  always_comb begin
    cfg_rdata = '0;
    if (addr_ok) cfg_rdata = words[cfg_addr];
  end

  // Sequencer: array writes in IDLE, then clear / shift / load with registered outputs.
  always_ff @(posedge mclk) begin
    if (reset) begin
      state_q           <= StIdle;
      ph_q              <= '0;
      bit_q             <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      serial_shift_rstn <= 1'b1;
      serial_clock      <= 1'b0;
      serial_data       <= 1'b0;
      serial_load       <= 1'b0;
      for (int k = 0; k < N; k++) words[k] <= GPIO_DEFAULTS;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cfg_wr && addr_ok) words[cfg_addr] <= cfg_wdata;
          if (start) begin
            state_q           <= StSrst;
            busy              <= 1'b1;
            serial_shift_rstn <= 1'b0;
            ph_q              <= '0;
          end
        end
        StSrst: begin
          if (ph_q == LastPh) begin
            ph_q              <= '0;
            serial_shift_rstn <= 1'b1;
            serial_data       <= flat[LastBit];
            bit_q             <= '0;
            state_q           <= StShiftLo;
          end else begin
            ph_q <= ph_q + PW'(1);
          end
        end
        StShiftLo: begin
          if (ph_q == LastPh) begin
            ph_q         <= '0;
            serial_clock <= 1'b1;
            state_q      <= StShiftHi;
          end else begin
            ph_q <= ph_q + PW'(1);
          end
        end
        StShiftHi: begin
          if (ph_q == LastPh) begin
            ph_q         <= '0;
            serial_clock <= 1'b0;
            if (bit_q == LastBit) begin
              serial_data <= 1'b0;
              serial_load <= 1'b1;
              state_q     <= StLoad;
            end else begin
              // Next bit is captured as its low phase begins.
              serial_data <= flat[LastBit - bit_q - BW'(1)];
              bit_q       <= bit_q + BW'(1);
              state_q     <= StShiftLo;
            end
          end else begin
            ph_q <= ph_q + PW'(1);
          end
        end
        StLoad: begin
          if (ph_q == LastPh) begin
            ph_q        <= '0;
            serial_load <= 1'b0;
            done        <= 1'b1;
            state_q     <= StDone;
          end else begin
            ph_q <= ph_q + PW'(1);
          end
        end
        StDone: begin
          // busy stays high through this cycle and falls together with done.
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Bench for gpio_serial_loader: two instances (CLK_DIV=1 and CLK_DIV=3) share all inputs.
// Each instance drives a model of the pad chain; results are scored against a queue.
module tb_gpio_serial_loader;

  localparam int N = 9;
  localparam int P = 16;
  localparam int B = N * P;
  localparam logic [P-1:0] DEF = 16'h3000;

  typedef struct packed {
    logic [B-1:0] flat;
    logic [31:0]  cyc;
    logic [31:0]  scyc;
    logic         first;
  } exp_t;

  logic          mclk = 1'b0;
  logic          reset, cfg_wr, start;
  logic [3:0]    cfg_addr;
  logic [P-1:0]  cfg_wdata;
  logic [P-1:0]  rdata [2];
  logic          busy [2], done [2], srstn [2], sclk [2], sdata [2], sload [2];

  int            n_chk = 0, n_fail = 0, ncyc = 0;
  logic [P-1:0]  exp_words [N];
  exp_t          sb0 [$], sb1 [$];

  logic [B-1:0]  chain [2], latch [2];
  logic          prev_clk [2], prev_data [2], prev_load [2], prev_done [2], first_bit [2];
  int            n_srst [2], n_load [2], n_lpulse [2], n_rise [2], n_hi [2], n_lo [2], n_chg [2];

  always #5 mclk = ~mclk;

  gpio_serial_loader #(.OPENFRAME_IO_PADS(9), .PAD_CTRL_BITS(16), .GPIO_DEFAULTS(16'h3000),
                       .CLK_DIV(1)) u_dut1 (
    .mclk(mclk), .reset(reset), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_rdata(rdata[0]), .start(start), .busy(busy[0]), .done(done[0]),
    .serial_shift_rstn(srstn[0]), .serial_clock(sclk[0]), .serial_data(sdata[0]),
    .serial_load(sload[0])
  );

  gpio_serial_loader #(.OPENFRAME_IO_PADS(9), .PAD_CTRL_BITS(16), .GPIO_DEFAULTS(16'h3000),
                       .CLK_DIV(3)) u_dut3 (
    .mclk(mclk), .reset(reset), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_rdata(rdata[1]), .start(start), .busy(busy[1]), .done(done[1]),
    .serial_shift_rstn(srstn[1]), .serial_clock(sclk[1]), .serial_data(sdata[1]),
    .serial_load(sload[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, ncyc);
    end
  endtask

  function automatic int dval(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int sb_size(input int i);
    return (i == 0) ? sb0.size() : sb1.size();
  endfunction

  function automatic exp_t sb_front(input int i);
    return (i == 0) ? sb0[0] : sb1[0];
  endfunction

  task automatic clear_stats(input int i);
    n_srst[i] = 0; n_load[i] = 0; n_lpulse[i] = 0; n_rise[i] = 0;
    n_hi[i] = 0; n_lo[i] = 0; n_chg[i] = 0;
  endtask

  // Chain model and scoreboard consumer, sampled mid-cycle.
  always @(negedge mclk) begin
    exp_t e;
    ncyc++;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        clear_stats(i);
      end else begin
        if (!srstn[i]) begin n_srst[i]++; chain[i] = '0; end
        if (sload[i]) n_load[i]++;
        if (sload[i] && !prev_load[i]) begin n_lpulse[i]++; latch[i] = chain[i]; end
        if (sclk[i] && !prev_clk[i]) begin
          if (n_rise[i] == 0) first_bit[i] = sdata[i];
          chain[i] = {chain[i][B-2:0], sdata[i]};
          n_rise[i]++;
        end
        if (sclk[i]) n_hi[i]++;
        if (sclk[i] && prev_clk[i] && (sdata[i] != prev_data[i])) n_chg[i]++;
        if (busy[i] && srstn[i] && !sload[i] && !sclk[i] && !done[i]) n_lo[i]++;
        if (prev_done[i]) chk($sformatf("busy_fall[%0d]", i), busy[i], 0);
        if (sb_size(i) > 0 && ncyc == sb_front(i).scyc + 1)
          chk($sformatf("busy_rise[%0d]", i), busy[i], 1);
        if (done[i]) begin
          chk($sformatf("done_has_start[%0d]", i), sb_size(i), 1);
          if (sb_size(i) > 0) begin
            e = sb_front(i);
            if (i == 0) void'(sb0.pop_front()); else void'(sb1.pop_front());
            chk($sformatf("done_cycle[%0d]", i), ncyc, e.cyc);
            chk($sformatf("busy_in_done[%0d]", i), busy[i], 1);
            chk($sformatf("srst_cycles[%0d]", i), n_srst[i], dval(i));
            chk($sformatf("load_cycles[%0d]", i), n_load[i], dval(i));
            chk($sformatf("load_pulses[%0d]", i), n_lpulse[i], 1);
            chk($sformatf("clock_rises[%0d]", i), n_rise[i], B);
            chk($sformatf("hi_cycles[%0d]", i), n_hi[i], dval(i) * B);
            chk($sformatf("lo_cycles[%0d]", i), n_lo[i], dval(i) * B);
            chk($sformatf("data_change_hi[%0d]", i), n_chg[i], 0);
            chk($sformatf("first_bit[%0d]", i), first_bit[i], e.first);
            for (int k = 0; k < N; k++)
              chk($sformatf("pad%0d[%0d]", k, i), latch[i][k*P +: P], e.flat[k*P +: P]);
          end
          clear_stats(i);
        end
      end
      prev_clk[i]  = sclk[i];
      prev_data[i] = sdata[i];
      prev_load[i] = sload[i];
      prev_done[i] = done[i];
    end
  end

  task automatic push_expect();
    exp_t e;
    for (int k = 0; k < N; k++) e.flat[k*P +: P] = exp_words[k];
    e.first = exp_words[N-1][P-1];
    e.scyc  = ncyc;
    e.cyc   = ncyc + 2 * 1 + 2 * 1 * B + 1;
    sb0.push_back(e);
    e.cyc   = ncyc + 2 * 3 + 2 * 3 * B + 1;
    sb1.push_back(e);
  endtask

  // Start, optionally with a same-cycle config write.
  task automatic do_start(input logic accepted, input logic wr, input int a, input logic [P-1:0] d);
    @(negedge mclk); #1;
    if (wr) begin
      cfg_wr = 1'b1; cfg_addr = 4'(a); cfg_wdata = d;
      exp_words[a] = d;
    end
    if (accepted) push_expect();
    start = 1'b1;
    @(negedge mclk); #1;
    start = 1'b0; cfg_wr = 1'b0;
  endtask

  task automatic cfg_write(input int a, input logic [P-1:0] d, input logic accepted);
    @(negedge mclk); #1;
    cfg_addr = 4'(a); cfg_wdata = d; cfg_wr = 1'b1;
    @(negedge mclk); #1;
    cfg_wr = 1'b0;
    if (accepted) exp_words[a] = d;
  endtask

  task automatic chk_read(input int a, input logic [P-1:0] exp);
    cfg_addr = 4'(a);
    #1;
    chk($sformatf("rdata%0d[0]", a), rdata[0], exp);
    chk($sformatf("rdata%0d[1]", a), rdata[1], exp);
  endtask

  task automatic chk_all_words();
    for (int a = 0; a < N; a++) chk_read(a, exp_words[a]);
  endtask

  task automatic wait_idle();
    int t;
    for (t = 0; t < 3000 && (sb0.size() != 0 || sb1.size() != 0); t++) @(negedge mclk);
    chk("op_timeout", sb0.size() + sb1.size(), 0);
    repeat (3) @(negedge mclk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_busy[%0d]", tag, i), busy[i], 0);
      chk($sformatf("%s_done[%0d]", tag, i), done[i], 0);
      chk($sformatf("%s_srstn[%0d]", tag, i), srstn[i], 1);
      chk($sformatf("%s_sclk[%0d]", tag, i), sclk[i], 0);
      chk($sformatf("%s_sdata[%0d]", tag, i), sdata[i], 0);
      chk($sformatf("%s_sload[%0d]", tag, i), sload[i], 0);
    end
  endtask

  initial begin
    reset = 1'b1; cfg_wr = 1'b0; start = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    for (int k = 0; k < N; k++) exp_words[k] = DEF;
    for (int i = 0; i < 2; i++) begin
      chain[i] = '0; latch[i] = '0; first_bit[i] = 1'b0;
      prev_clk[i] = 1'b0; prev_data[i] = 1'b0; prev_load[i] = 1'b0; prev_done[i] = 1'b0;
      clear_stats(i);
    end
    repeat (3) @(negedge mclk);
    #1;
    chk_reset_outputs("reset");
    reset = 1'b0;
    chk_all_words();

    // Defaults shifted out.
    do_start(1'b1, 1'b0, 0, '0);
    wait_idle();

    // Custom words at both chain ends.
    cfg_write(0, 16'hA5C3, 1'b1);
    cfg_write(8, 16'h0001, 1'b1);
    chk_all_words();
    do_start(1'b1, 1'b0, 0, '0);
    wait_idle();

    // Restart and write attempts while busy are dropped.
    do_start(1'b1, 1'b0, 0, '0);
    repeat (48) @(negedge mclk);
    do_start(1'b0, 1'b0, 0, '0);
    cfg_write(2, 16'hFFFF, 1'b0);
    chk_read(2, DEF);
    wait_idle();
    chk_read(2, DEF);

    // Write and start in the same cycle: the new value is sent.
    do_start(1'b1, 1'b1, 5, 16'h0F0F);
    wait_idle();
    chk_read(5, 16'h0F0F);

    // Reset in the middle of shifting aborts without a load strobe.
    do_start(1'b1, 1'b0, 0, '0);
    for (int t = 0; t < 2000 && n_rise[0] < 70; t++) @(negedge mclk);
    #1;
    chk("reached_bit70", n_rise[0], 70);
    chk("no_load_before_abort[0]", n_lpulse[0], 0);
    chk("no_load_before_abort[1]", n_lpulse[1], 0);
    reset = 1'b1;
    sb0.delete(); sb1.delete();
    @(negedge mclk); #1;
    chk_reset_outputs("abort");
    reset = 1'b0;
    for (int k = 0; k < N; k++) exp_words[k] = DEF;
    chk_all_words();
    repeat (10) @(negedge mclk);
    #1;
    chk("no_load_after_abort[0]", n_lpulse[0], 0);
    chk("no_load_after_abort[1]", n_lpulse[1], 0);
    do_start(1'b1, 1'b0, 0, '0);
    wait_idle();

    // Out-of-range write is ignored and reads as zero.
    cfg_write(9, 16'h1234, 1'b0);
    chk_read(9, 16'h0000);
    chk_all_words();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
